// File: rtl/fracnet_sdiv_restore_if.sv
// rtl/fracnet_sdiv_restore_if.sv - operand/result handshake bundle for the restoring signed divider
interface fracnet_sdiv_restore_if #(
  parameter int DIVIDEND_W = 43,
  parameter int DIVISOR_W  = 24,
  parameter int QUOT_W     = 18
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DIVIDEND_W-1:0] dividend;
  logic signed [DIVISOR_W-1:0]  divisor;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [QUOT_W-1:0]     quotient;
  logic signed [DIVISOR_W-1:0]  remainder;
  logic                         ovf;
  logic                         dbz;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, ovf, dbz
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, ovf, dbz
  );
endinterface

// File: rtl/fracnet_sdiv_restore.sv
// rtl/fracnet_sdiv_restore.sv - iterative restoring signed divider, saturated quotient, exact remainder
module fracnet_sdiv_restore #(
  parameter int DIVIDEND_W = 43,
  parameter int DIVISOR_W  = 24,
  parameter int QUOT_W     = 18
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  fracnet_sdiv_restore_if.slave    io
);
  localparam int CW = $clog2(DIVIDEND_W);
  localparam logic signed [QUOT_W-1:0] Q_MAX = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic signed [QUOT_W-1:0] Q_MIN = {1'b1, {(QUOT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

  state_t                      state_q;
  logic [CW-1:0]               cnt_q;
  logic [DIVIDEND_W-1:0]       acc_q;
  logic [DIVISOR_W-1:0]        bmag_q;
  logic [DIVISOR_W:0]          pr_q;
  logic                        neg_rem_q;
  logic                        neg_quot_q;
  logic                        zero_div_q;
  logic                        in_ready_q;
  logic                        out_valid_q;
  logic signed [QUOT_W-1:0]    quot_q;
  logic signed [DIVISOR_W-1:0] rem_q;
  logic                        ovf_q;
  logic                        dbz_q;

  logic [DIVIDEND_W-1:0]       amag_d;
  logic [DIVISOR_W-1:0]        bmag_d;
  logic [DIVISOR_W:0]          shifted_d;
  logic                        qbit_d;
  logic [DIVISOR_W:0]          pr_d;
  logic [DIVIDEND_W-1:0]       acc_d;
  logic signed [DIVIDEND_W:0]  qsigned_d;
  logic signed [QUOT_W-1:0]    qsat_d;
  logic                        qclip_d;
  logic [DIVISOR_W-1:0]        rem_d;

  // acc_q starts as |dividend| and shifts quotient bits in from the right as dividend bits leave
  always_comb begin
    amag_d    = io.dividend[DIVIDEND_W-1] ? DIVIDEND_W'(-io.dividend) : DIVIDEND_W'(io.dividend);
    bmag_d    = io.divisor[DIVISOR_W-1]   ? DIVISOR_W'(-io.divisor)   : DIVISOR_W'(io.divisor);
    shifted_d = {pr_q[DIVISOR_W-1:0], acc_q[DIVIDEND_W-1]};
    qbit_d    = shifted_d >= {1'b0, bmag_q};
    pr_d      = qbit_d ? shifted_d - {1'b0, bmag_q} : shifted_d;
    acc_d     = {acc_q[DIVIDEND_W-2:0], qbit_d};
  end

  always_comb begin
    qsigned_d = neg_quot_q ? -$signed({1'b0, acc_q}) : $signed({1'b0, acc_q});
    qsat_d    = qsigned_d[QUOT_W-1:0];
    qclip_d   = 1'b0;
    if (qsigned_d > Q_MAX) begin
      qsat_d  = Q_MAX;
      qclip_d = 1'b1;
    end else if (qsigned_d < Q_MIN) begin
      qsat_d  = Q_MIN;
      qclip_d = 1'b1;
    end
    rem_d = neg_rem_q ? -pr_q[DIVISOR_W-1:0] : pr_q[DIVISOR_W-1:0];
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      bmag_q      <= '0;
      pr_q        <= '0;
      neg_rem_q   <= 1'b0;
      neg_quot_q  <= 1'b0;
      zero_div_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (io.in_valid && in_ready_q) begin
            acc_q      <= amag_d;
            bmag_q     <= bmag_d;
            pr_q       <= '0;
            neg_rem_q  <= io.dividend[DIVIDEND_W-1];
            neg_quot_q <= io.dividend[DIVIDEND_W-1] ^ io.divisor[DIVISOR_W-1];
            zero_div_q <= (io.divisor == '0);
            cnt_q      <= CW'(DIVIDEND_W-1);
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          pr_q  <= pr_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= FIN;
        end
        FIN: begin
          // a zero divisor leaves garbage in acc/pr, so its result is forced here
          if (zero_div_q) begin
            quot_q <= neg_rem_q ? Q_MIN : Q_MAX;
            rem_q  <= '0;
            ovf_q  <= 1'b1;
            dbz_q  <= 1'b1;
          end else begin
            quot_q <= qsat_d;
            rem_q  <= $signed(rem_d);
            ovf_q  <= qclip_d;
            dbz_q  <= 1'b0;
          end
          state_q <= DONE;
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (io.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.quotient  = quot_q;
  assign io.remainder = rem_q;
  assign io.ovf       = ovf_q;
  assign io.dbz       = dbz_q;
endmodule

// File: tb/tb_fracnet_sdiv_restore.sv
// tb/tb_fracnet_sdiv_restore.sv - directed self-checking bench for fracnet_sdiv_restore
module tb_fracnet_sdiv_restore;
  localparam int DW = 43;
  localparam int VW = 24;
  localparam int QW = 18;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   lat;

  always #5 ap_clk = ~ap_clk;

  fracnet_sdiv_restore_if #(.DIVIDEND_W(DW), .DIVISOR_W(VW), .QUOT_W(QW)) io ();

  fracnet_sdiv_restore #(.DIVIDEND_W(DW), .DIVISOR_W(VW), .QUOT_W(QW)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .io       (io)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input longint a, input longint b);
    int n = 0;
    @(negedge ap_clk);
    while (!io.in_ready && n < 200) begin
      @(negedge ap_clk);
      n++;
    end
    chk("send_ready", io.in_ready, 1);
    io.dividend = DW'(a);
    io.divisor  = VW'(b);
    io.in_valid = 1'b1;
    @(posedge ap_clk);
    #1 io.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (n < 100) begin
      @(posedge ap_clk);
      #1 n++;
      if (io.out_valid) break;
    end
  endtask

  task automatic release_out(input string tag);
    @(negedge ap_clk);
    io.out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    chk({tag, "_vld_drop"}, io.out_valid, 0);
    chk({tag, "_rdy_rise"}, io.in_ready, 1);
    io.out_ready = 1'b0;
  endtask

  task automatic run(input longint a, input longint b, input longint eq, input longint er,
                     input logic eo, input logic ed, input string tag);
    send(a, b);
    wait_out(lat);
    chk({tag, "_lat"}, lat, 45);
    chk({tag, "_q"}, io.quotient, eq);
    chk({tag, "_r"}, io.remainder, er);
    chk({tag, "_ovf"}, io.ovf, eo);
    chk({tag, "_dbz"}, io.dbz, ed);
    release_out(tag);
  endtask

  initial begin
    io.in_valid  = 1'b0;
    io.out_ready = 1'b0;
    io.dividend  = '0;
    io.divisor   = '0;

    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_in_ready", io.in_ready, 0);
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_q", io.quotient, 0);
    chk("rst_r", io.remainder, 0);
    chk("rst_ovf", io.ovf, 0);
    chk("rst_dbz", io.dbz, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1 chk("rel_in_ready", io.in_ready, 1);

    run(-300000, -300, 1000, 0, 1'b0, 1'b0, "roundtrip");
    run(7, -2, -3, 1, 1'b0, 1'b0, "p7_m2");
    run(-7, 2, -3, -1, 1'b0, 1'b0, "m7_p2");
    run(-7, -2, 3, -1, 1'b0, 1'b0, "m7_m2");
    run(100000, -7, -14285, 5, 1'b0, 1'b0, "p100k_m7");
    run(0, 5, 0, 0, 1'b0, 1'b0, "zero_div");
    run(64'sd1099511627776, 1, 131071, 0, 1'b1, 1'b0, "sat_2p40");
    run(-64'sd4398046511104, -1, 131071, 0, 1'b1, 1'b0, "sat_m2p42");
    run(-131072, 1, -131072, 0, 1'b0, 1'b0, "min_exact");
    run(12345, 0, 131071, 0, 1'b1, 1'b1, "dbz_pos");
    run(-5, 0, -131072, 0, 1'b1, 1'b1, "dbz_neg");

    send(1000, 7);
    wait_out(lat);
    chk("bp_lat", lat, 45);
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      io.in_valid = 1'b1;
      io.dividend = DW'(50);
      io.divisor  = VW'(5);
      @(posedge ap_clk);
      #1;
      chk("bp_out_valid", io.out_valid, 1);
      chk("bp_in_ready", io.in_ready, 0);
      chk("bp_q", io.quotient, 142);
      chk("bp_r", io.remainder, 6);
    end
    @(negedge ap_clk);
    io.out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    chk("bp_vld_drop", io.out_valid, 0);
    chk("bp_rdy_rise", io.in_ready, 1);
    @(negedge ap_clk);
    io.out_ready = 1'b0;
    @(posedge ap_clk);
    #1;
    chk("b2b_accepted", io.in_ready, 0);
    io.in_valid = 1'b0;
    wait_out(lat);
    chk("b2b_lat", lat, 45);
    chk("b2b_q", io.quotient, 10);
    chk("b2b_r", io.remainder, 0);
    release_out("b2b");

    send(123456, -100);
    repeat (20) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", io.out_valid, 0);
    chk("mid_rst_in_ready", io.in_ready, 0);
    chk("mid_rst_q", io.quotient, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1 chk("mid_rel_in_ready", io.in_ready, 1);
    run(600, 25, 24, 0, 1'b0, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
